// File: rtl/fp_round_pipe.sv
// Rounding/packing stage behind fp_mul: two-stage valid/ready pipeline that applies the
// IEEE-754 rounding mode, resolves overflow/underflow and produces {NV,DZ,OF,UF,NX}.
package fp_pkg;
  typedef enum logic [1:0] {FP16, FP32, FP64} fp_format_e;

  function automatic int unsigned exp_bits(fp_format_e f);
    case (f)
      FP16:    return 5;
      FP64:    return 11;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e f);
    case (f)
      FP16:    return 10;
      FP64:    return 52;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e f);
    return 1 + exp_bits(f) + man_bits(f);
  endfunction

  // FP32 view of the unrounded bundle; the module port carries the same layout flattened.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef struct packed {
    fp32_t       u_result;
    logic [1:0]  rs;
    logic        round_en;
    logic        invalid;
    logic [1:0]  exp_cout;
  } uround_res_t;
endpackage

module fp_round_pipe
  import fp_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  localparam int unsigned EW = exp_bits(FP_FORMAT),
  localparam int unsigned MW = man_bits(FP_FORMAT),
  localparam int unsigned FW = 1 + EW + MW,
  localparam int unsigned UW = FW + 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [UW-1:0] urnd_i,
  input  logic [2:0]    rnd_mode_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [FW-1:0] result_o,
  output logic [4:0]    fflags_o
);

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] mant;
  } fp_t;

  typedef struct packed {
    fp_t        u_result;
    logic [1:0] rs;
    logic       round_en;
    logic       invalid;
    logic [1:0] exp_cout;
  } urnd_t;

  typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} rnd_e;

  function automatic rnd_e decode_mode(logic [2:0] m);
    if (m > 3'd4) return RNE;
    return rnd_e'(m);
  endfunction

  urnd_t w_in;
  rnd_e  w_mode;
  logic  w_inc;
  logic  w_s2_adv;

  assign w_in     = urnd_i;
  assign w_mode   = decode_mode(rnd_mode_i);
  assign w_s2_adv = ~valid_o | ready_i;

  always_comb begin
    w_inc = 1'b0;
    case (w_mode)
      RNE:     w_inc = w_in.rs[1] & (w_in.rs[0] | w_in.u_result.mant[0]);
      RTZ:     w_inc = 1'b0;
      RDN:     w_inc = (|w_in.rs) & w_in.u_result.sign;
      RUP:     w_inc = (|w_in.rs) & ~w_in.u_result.sign;
      RMM:     w_inc = w_in.rs[1];
      default: w_inc = 1'b0;
    endcase
  end

  logic       r_s1_v;
  fp_t        r_s1_u;
  logic       r_s1_re;
  logic       r_s1_inv;
  logic [1:0] r_s1_ec;
  rnd_e       r_s1_mode;
  logic       r_s1_inc;
  logic       r_s1_nx;

  assign ready_o = ~r_s1_v | w_s2_adv;

  // While ready_o is high stage 1 either takes a new op or drains into stage 2.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_v    <= 1'b0;
      r_s1_u    <= '0;
      r_s1_re   <= 1'b0;
      r_s1_inv  <= 1'b0;
      r_s1_ec   <= 2'b00;
      r_s1_mode <= RNE;
      r_s1_inc  <= 1'b0;
      r_s1_nx   <= 1'b0;
    end else begin
      if (flush_i) begin
        r_s1_v <= 1'b0;
      end else if (ready_o) begin
        r_s1_v <= valid_i;
      end
      if (valid_i & ready_o) begin
        r_s1_u    <= w_in.u_result;
        r_s1_re   <= w_in.round_en;
        r_s1_inv  <= w_in.invalid;
        r_s1_ec   <= w_in.exp_cout;
        r_s1_mode <= w_mode;
        r_s1_inc  <= w_inc;
        r_s1_nx   <= |w_in.rs;
      end
    end
  end

  logic [EW+MW-1:0] w_sum;
  logic             w_sg;
  logic             w_away;
  logic             w_ovf_pre;
  logic             w_unf;
  logic             w_sum_ovf;
  fp_t              w_res;
  logic             w_of;
  logic             w_uf;
  logic             w_nx;

  assign w_sum     = {r_s1_u.exp, r_s1_u.mant} + (EW+MW)'(r_s1_inc);
  assign w_sg      = r_s1_u.sign;
  assign w_away    = ((r_s1_mode == RUP) & ~w_sg) | ((r_s1_mode == RDN) & w_sg);
  assign w_ovf_pre = (r_s1_ec == 2'b01) | (&r_s1_u.exp);
  assign w_unf     = r_s1_ec[1];
  assign w_sum_ovf = &w_sum[EW+MW-1:MW];

  // Explicit overflow from the multiplier wins, then negative exponent, then rounding carry-out.
  always_comb begin
    w_res = r_s1_u;
    w_of  = 1'b0;
    w_uf  = 1'b0;
    w_nx  = 1'b0;
    if (r_s1_re) begin
      if (w_ovf_pre | (~w_unf & w_sum_ovf)) begin
        w_of = 1'b1;
        w_nx = 1'b1;
        if ((r_s1_mode == RNE) | (r_s1_mode == RMM) | w_away) begin
          w_res.exp  = '1;
          w_res.mant = '0;
        end else begin
          w_res.exp  = {{(EW-1){1'b1}}, 1'b0};
          w_res.mant = '1;
        end
      end else if (w_unf) begin
        w_uf       = 1'b1;
        w_nx       = 1'b1;
        w_res.exp  = '0;
        w_res.mant = MW'(w_away);
      end else begin
        w_res.exp  = w_sum[EW+MW-1:MW];
        w_res.mant = w_sum[MW-1:0];
        w_nx       = r_s1_nx;
        w_uf       = r_s1_nx & ~(|w_sum[EW+MW-1:MW]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o  <= 1'b0;
      result_o <= '0;
      fflags_o <= '0;
    end else begin
      if (flush_i) begin
        valid_o <= 1'b0;
      end else if (w_s2_adv) begin
        valid_o <= r_s1_v;
      end
      if (w_s2_adv & r_s1_v) begin
        result_o <= w_res;
        fflags_o <= {r_s1_inv, 1'b0, w_of, w_uf, w_nx};
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Bench for fp_round_pipe (FP32): directed literal vectors, back-pressure, flush, async reset
// and a randomized stream, all scored against an arithmetic model of the rounding rules.
module tb_fp_round_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [37:0] urnd_i = '0;
  logic [2:0]  rnd_mode_i = 3'd0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;

  int total = 0;
  int bad = 0;
  bit rand_rdy = 1'b0;
  logic [36:0] sb[$];

  fp_round_pipe dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .urnd_i(urnd_i), .rnd_mode_i(rnd_mode_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .fflags_o(fflags_o)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] mkb(logic [31:0] u, logic [1:0] rs, logic re, logic inv,
                                      logic [1:0] ec);
    return {u, rs, re, inv, ec};
  endfunction

  // Returns {NV,DZ,OF,UF,NX, result}; magnitude handled as an integer exp*2^23+mant.
  function automatic logic [36:0] model(logic [37:0] b, logic [2:0] md);
    bit          sg;
    longint      ex, mn, mag;
    bit          r, s, re, inv, up, away, ovf, of, uf, nx;
    logic [1:0]  ec;
    int          mode;
    logic [31:0] res;
    sg   = b[37];
    ex   = longint'(b[36:29]);
    mn   = longint'(b[28:6]);
    r    = b[5];
    s    = b[4];
    re   = b[3];
    inv  = b[2];
    ec   = b[1:0];
    mode = (md > 3'd4) ? 0 : int'(md);
    of = 0; uf = 0; nx = 0;
    if (!re) return {inv, 4'b0000, b[37:6]};
    case (mode)
      0:       up = r && (s || (mn % 2 == 1));
      1:       up = 0;
      2:       up = (r || s) && sg;
      3:       up = (r || s) && !sg;
      default: up = r;
    endcase
    away = (mode == 3 && !sg) || (mode == 2 && sg);
    mag  = ex * 64'd8388608 + mn + (up ? 1 : 0);
    ovf  = (ec == 2'b01) || (ex == 255) || (!ec[1] && mag >= 255 * 64'd8388608);
    if (ovf) begin
      res = (mode == 0 || mode == 4 || away) ? 32'h7F80_0000 : 32'h7F7F_FFFF;
      of = 1; nx = 1;
    end else if (ec[1]) begin
      res = away ? 32'd1 : 32'd0;
      uf = 1; nx = 1;
    end else begin
      res = 32'(mag);
      nx = r || s;
      uf = nx && (mag < 64'd8388608);
    end
    res[31] = sg;
    return {inv, 1'b0, of, uf, nx, res};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every cycle valid_o is up, pop on transfer, then record new accepts.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got valid result %0h, expected no output", result_o);
        end else begin
          if ({fflags_o, result_o} !== sb[0]) begin
            bad++;
            $display("FAIL sb_result: got flags=%0h res=%0h expected flags=%0h res=%0h",
                     fflags_o, result_o, sb[0][36:32], sb[0][31:0]);
          end
          if (ready_i) void'(sb.pop_front());
        end
      end
      if (flush_i) sb.delete();
      else if (valid_i && ready_o) sb.push_back(model(urnd_i, rnd_mode_i));
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (rand_rdy) ready_i = ($urandom_range(0, 3) != 0);
  end

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic send(logic [37:0] b, logic [2:0] m);
    int n;
    urnd_i = b;
    rnd_mode_i = m;
    valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      total++; bad++;
      $display("FAIL send_timeout: got ready_o=0 for %0d cycles, expected accept", n);
    end
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || valid_o) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic latency_check(string tag);
    send(mkb(32'h3F80_0000, 2'b00, 1'b1, 1'b0, 2'b00), 3'd0);
    chk({tag, "_not_yet"}, 64'(valid_o), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 64'(valid_o), 64'd1);
    chk({tag, "_result"}, 64'(result_o), 64'h3F80_0000);
    chk({tag, "_flags"}, 64'(fflags_o), 64'd0);
    drain();
  endtask

  function automatic logic [37:0] rand_bundle();
    logic [7:0]  ex;
    logic [22:0] mn;
    logic [1:0]  ec;
    case ($urandom_range(0, 7))
      0:       ex = 8'hFE;
      1:       ex = 8'hFF;
      2:       ex = 8'h00;
      3:       ex = 8'h01;
      default: ex = 8'($urandom);
    endcase
    mn = ($urandom_range(0, 3) == 0) ? 23'h7F_FFFF : 23'($urandom);
    case ($urandom_range(0, 7))
      5:       ec = 2'b01;
      6:       ec = 2'b10;
      7:       ec = 2'b11;
      default: ec = 2'b00;
    endcase
    return {1'($urandom), ex, mn, 2'($urandom), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 7) == 0), ec};
  endfunction

  logic [37:0] dv_b[13];
  logic [2:0]  dv_m[13];
  logic [36:0] dv_e[13];

  initial begin
    dv_b[0]  = mkb(32'h3F80_0000, 2'b00, 1, 0, 2'b00); dv_m[0]  = 0; dv_e[0]  = {5'h00, 32'h3F80_0000};
    dv_b[1]  = mkb(32'h3F80_0000, 2'b10, 1, 0, 2'b00); dv_m[1]  = 0; dv_e[1]  = {5'h01, 32'h3F80_0000};
    dv_b[2]  = mkb(32'h3F80_0001, 2'b10, 1, 0, 2'b00); dv_m[2]  = 0; dv_e[2]  = {5'h01, 32'h3F80_0002};
    dv_b[3]  = mkb(32'h3F80_0001, 2'b10, 1, 0, 2'b00); dv_m[3]  = 4; dv_e[3]  = {5'h01, 32'h3F80_0002};
    dv_b[4]  = mkb(32'h3F80_0001, 2'b10, 1, 0, 2'b00); dv_m[4]  = 1; dv_e[4]  = {5'h01, 32'h3F80_0001};
    dv_b[5]  = mkb(32'h7F7F_FFFF, 2'b11, 1, 0, 2'b00); dv_m[5]  = 3; dv_e[5]  = {5'h05, 32'h7F80_0000};
    dv_b[6]  = mkb(32'h7F7F_FFFF, 2'b11, 1, 0, 2'b00); dv_m[6]  = 1; dv_e[6]  = {5'h01, 32'h7F7F_FFFF};
    dv_b[7]  = mkb(32'h3F80_0000, 2'b00, 1, 0, 2'b01); dv_m[7]  = 2; dv_e[7]  = {5'h05, 32'h7F7F_FFFF};
    dv_b[8]  = mkb(32'hFFC0_0000, 2'b00, 0, 1, 2'b00); dv_m[8]  = 0; dv_e[8]  = {5'h10, 32'hFFC0_0000};
    dv_b[9]  = mkb(32'h8000_0000, 2'b01, 1, 0, 2'b10); dv_m[9]  = 2; dv_e[9]  = {5'h03, 32'h8000_0001};
    dv_b[10] = mkb(32'h0000_0005, 2'b11, 1, 0, 2'b00); dv_m[10] = 0; dv_e[10] = {5'h03, 32'h0000_0006};
    dv_b[11] = mkb(32'h3F80_0001, 2'b10, 1, 0, 2'b00); dv_m[11] = 7; dv_e[11] = {5'h01, 32'h3F80_0002};
    dv_b[12] = mkb(32'hFF7F_FFFF, 2'b11, 1, 0, 2'b00); dv_m[12] = 2; dv_e[12] = {5'h05, 32'hFF80_0000};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_result_o", 64'(result_o), 64'd0);
    chk("rst_fflags_o", 64'(fflags_o), 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    latency_check("lat");

    for (int i = 0; i < 13; i++) begin
      chk($sformatf("model_vec%0d", i), 64'(model(dv_b[i], dv_m[i])), 64'(dv_e[i]));
      send(dv_b[i], dv_m[i]);
    end
    drain();

    ready_i = 1'b0;
    send(dv_b[2], dv_m[2]);
    send(dv_b[5], dv_m[5]);
    chk("bp_ready_low", 64'(ready_o), 64'd0);
    chk("bp_valid_high", 64'(valid_o), 64'd1);
    repeat (3) @(posedge clk);
    #1 ready_i = 1'b1;
    send(dv_b[9], dv_m[9]);
    send(dv_b[8], dv_m[8]);
    drain();

    ready_i = 1'b0;
    send(dv_b[1], dv_m[1]);
    send(dv_b[6], dv_m[6]);
    chk("flush_pre_valid", 64'(valid_o), 64'd1);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    chk("flush_valid_o", 64'(valid_o), 64'd0);
    chk("flush_ready_o", 64'(ready_o), 64'd1);
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk($sformatf("flush_no_stale%0d", i), 64'(valid_o), 64'd0);
    end
    drain();

    send(dv_b[3], dv_m[3]);
    send(dv_b[10], dv_m[10]);
    chk("arst_pre_valid", 64'(valid_o), 64'd1);
    #2 rst_n = 1'b0;
    sb.delete();
    #1 chk("arst_valid_drop", 64'(valid_o), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    latency_check("arst_lat");

    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      send(rand_bundle(), 3'($urandom_range(0, 7)));
    end
    rand_rdy = 1'b0;
    ready_i = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, expected finish before time limit");
    $fatal(1);
  end
endmodule
